// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-locked round-robin arbiter: merges NUM_S AXI4-Stream slaves onto one master,
// holding each grant until TLAST and truncating packets longer than MAX_BEATS.
module axis_pkt_rr_arbiter #(
    parameter int NUM_S      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 32,
    parameter int MAX_BEATS  = 256
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [NUM_S-1:0]                  s_tvalid,
    output logic [NUM_S-1:0]                  s_tready,
    input  logic [NUM_S*DATA_WIDTH-1:0]       s_tdata,
    input  logic [NUM_S*DATA_WIDTH/8-1:0]     s_tkeep,
    input  logic [NUM_S*DATA_WIDTH/8-1:0]     s_tstrb,
    input  logic [NUM_S-1:0]                  s_tlast,
    input  logic [NUM_S*ID_WIDTH-1:0]         s_tid,
    input  logic [NUM_S*DEST_WIDTH-1:0]       s_tdest,
    input  logic [NUM_S*USER_WIDTH-1:0]       s_tuser,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic [DATA_WIDTH-1:0]             m_tdata,
    output logic [DATA_WIDTH/8-1:0]           m_tkeep,
    output logic [DATA_WIDTH/8-1:0]           m_tstrb,
    output logic                              m_tlast,
    output logic [ID_WIDTH-1:0]               m_tid,
    output logic [DEST_WIDTH-1:0]             m_tdest,
    output logic [USER_WIDTH-1:0]             m_tuser,
    output logic [$clog2(NUM_S)-1:0]          grant_idx,
    output logic                              grant_busy,
    output logic                              err_overlen,
    input  logic                              err_clr
);
    localparam int IDX_W  = $clog2(NUM_S);
    localparam int CNT_W  = $clog2(MAX_BEATS);
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state_r, state_next_s;
    logic [IDX_W-1:0]   grant_idx_r, last_grant_r, pick_idx_s, cand_s;
    logic               pick_valid_s;
    logic [CNT_W-1:0]   beat_cnt_r;
    logic               err_overlen_r;
    logic               forced_last_s, hs_s;

    // Round-robin search; scanning downward leaves the nearest requester after last_grant.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = last_grant_r;
        cand_s       = last_grant_r;
        for (int k = NUM_S; k >= 1; k--) begin
            cand_s = IDX_W'((int'(last_grant_r) + k) % NUM_S);
            if (s_tvalid[cand_s]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_valid_s = pick_valid_s;
                pick_idx_s   = pick_idx_s;
            end
        end
    end

    // Data fields always follow the registered grant, so they hold the last port while idle.
    assign m_tdata = s_tdata[grant_idx_r*DATA_WIDTH +: DATA_WIDTH];
    assign m_tkeep = s_tkeep[grant_idx_r*KEEP_W +: KEEP_W];
    assign m_tstrb = s_tstrb[grant_idx_r*KEEP_W +: KEEP_W];
    assign m_tid   = s_tid[grant_idx_r*ID_WIDTH +: ID_WIDTH];
    assign m_tdest = s_tdest[grant_idx_r*DEST_WIDTH +: DEST_WIDTH];
    assign m_tuser = s_tuser[grant_idx_r*USER_WIDTH +: USER_WIDTH];

    assign grant_idx   = grant_idx_r;
    assign grant_busy  = (state_r == BUSY);
    assign err_overlen = err_overlen_r;

    // Handshake pass-through and forced TLAST on the final permitted beat.
    always_comb begin
        s_tready      = '0;
        forced_last_s = (beat_cnt_r == LAST_BEAT);
        m_tlast       = s_tlast[grant_idx_r] | forced_last_s;
        if (state_r == BUSY) begin
            m_tvalid              = s_tvalid[grant_idx_r];
            s_tready[grant_idx_r] = m_tready;
        end else begin
            m_tvalid = 1'b0;
        end
        hs_s = m_tvalid & m_tready;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) state_next_s = BUSY;
                else              state_next_s = IDLE;
            end
            BUSY: begin
                if (hs_s && m_tlast) state_next_s = IDLE;
                else                 state_next_s = BUSY;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, grant, beat counter and sticky over-length flag.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r       <= IDLE;
            grant_idx_r   <= '0;
            last_grant_r  <= IDX_W'(NUM_S - 1);
            beat_cnt_r    <= '0;
            err_overlen_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        grant_idx_r  <= pick_idx_s;
                        last_grant_r <= pick_idx_s;
                        beat_cnt_r   <= '0;
                    end
                end
                BUSY: begin
                    if (hs_s && m_tlast) beat_cnt_r <= '0;
                    else if (hs_s)       beat_cnt_r <= beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                default: beat_cnt_r <= '0;
            endcase
            // Set beats clear when both happen together.
            if (hs_s && forced_last_s && !s_tlast[grant_idx_r]) err_overlen_r <= 1'b1;
            else if (err_clr)                                    err_overlen_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed testbench for axis_pkt_rr_arbiter (4 ports, MAX_BEATS=4).
module tb_axis_pkt_rr_arbiter;
    localparam int NS = 4, DW = 32, KW = 4, IW = 4, DSTW = 4, UW = 32, MB = 4;
    localparam int RDY_T [5] = '{1, 0, 0, 1, 1};
    localparam int IDX_T [5] = '{0, 1, 1, 1, 2};

    logic aclk = 1'b0;
    logic areset, m_tready, err_clr;
    logic [NS-1:0] s_tvalid, s_tready, s_tlast;
    logic [NS*DW-1:0] s_tdata;
    logic [NS*KW-1:0] s_tkeep, s_tstrb;
    logic [NS*IW-1:0] s_tid;
    logic [NS*DSTW-1:0] s_tdest;
    logic [NS*UW-1:0] s_tuser;
    logic m_tvalid, m_tlast, grant_busy, err_overlen;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep, m_tstrb;
    logic [IW-1:0] m_tid;
    logic [DSTW-1:0] m_tdest;
    logic [UW-1:0] m_tuser;
    logic [1:0] grant_idx;

    logic        src_valid [NS];
    logic        src_last  [NS];
    logic [31:0] src_data  [NS];

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    for (genvar p = 0; p < NS; p++) begin : g_src
        assign s_tvalid[p]             = src_valid[p];
        assign s_tlast[p]              = src_last[p];
        assign s_tdata[p*DW +: DW]     = src_data[p];
        assign s_tkeep[p*KW +: KW]     = 4'hF;
        assign s_tstrb[p*KW +: KW]     = 4'(p + 8);
        assign s_tid[p*IW +: IW]       = 4'(p + 3);
        assign s_tdest[p*DSTW +: DSTW] = 4'(p + 1);
        assign s_tuser[p*UW +: UW]     = ~src_data[p];
    end

    axis_pkt_rr_arbiter #(
        .NUM_S(NS), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSTW),
        .USER_WIDTH(UW), .MAX_BEATS(MB)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tstrb(s_tstrb), .s_tlast(s_tlast),
        .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tstrb(m_tstrb), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .grant_idx(grant_idx), .grant_busy(grant_busy),
        .err_overlen(err_overlen), .err_clr(err_clr)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input logic [31:0] d, input logic l);
        src_valid[p] = v;
        src_data[p]  = d;
        src_last[p]  = l;
    endtask

    task automatic clear_all();
        for (int p = 0; p < NS; p++) set_port(p, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        tick();
        areset = 1'b0;
    endtask

    task automatic test_reset();
        m_tready = 1'b1;
        err_clr  = 1'b0;
        clear_all();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        #1;
        total++; if (s_tready !== 4'b0000) begin bad++; $display("FAIL reset_s_tready: got=%b exp=%b", s_tready, 4'b0000); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid: got=%b exp=0", m_tvalid); end
        total++; if (grant_busy !== 1'b0) begin bad++; $display("FAIL reset_grant_busy: got=%b exp=0", grant_busy); end
        total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL reset_grant_idx: got=%0d exp=0", grant_idx); end
        total++; if (err_overlen !== 1'b0) begin bad++; $display("FAIL reset_err_overlen: got=%b exp=0", err_overlen); end
    endtask

    task automatic test_single_packet();
        set_port(2, 1'b1, 32'hA0, 1'b0);
        #1;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL single_idle_mvalid: got=%b exp=0", m_tvalid); end
        total++; if (s_tready !== 4'b0000) begin bad++; $display("FAIL single_idle_sready: got=%b exp=0000", s_tready); end
        tick();
        for (int b = 0; b < 3; b++) begin
            set_port(2, 1'b1, 32'hA0 + 32'(b), (b == 2));
            #1;
            total++; if (grant_busy !== 1'b1) begin bad++; $display("FAIL single_busy b%0d: got=%b exp=1", b, grant_busy); end
            total++; if (grant_idx !== 2'd2) begin bad++; $display("FAIL single_grant b%0d: got=%0d exp=2", b, grant_idx); end
            total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL single_mvalid b%0d: got=%b exp=1", b, m_tvalid); end
            total++; if (m_tdata !== 32'hA0 + 32'(b)) begin bad++; $display("FAIL single_data b%0d: got=%h exp=%h", b, m_tdata, 32'hA0 + 32'(b)); end
            total++; if (m_tlast !== (b == 2)) begin bad++; $display("FAIL single_last b%0d: got=%b exp=%b", b, m_tlast, (b == 2)); end
            total++; if (s_tready !== 4'b0100) begin bad++; $display("FAIL single_sready b%0d: got=%b exp=0100", b, s_tready); end
            if (b == 0) begin
                total++; if (m_tid !== 4'd5) begin bad++; $display("FAIL single_tid: got=%0d exp=5", m_tid); end
                total++; if (m_tdest !== 4'd3) begin bad++; $display("FAIL single_tdest: got=%0d exp=3", m_tdest); end
                total++; if (m_tuser !== 32'hFFFFFF5F) begin bad++; $display("FAIL single_tuser: got=%h exp=ffffff5f", m_tuser); end
                total++; if (m_tstrb !== 4'hA || m_tkeep !== 4'hF) begin bad++; $display("FAIL single_keep_strb: got=%h/%h exp=f/a", m_tkeep, m_tstrb); end
            end
            tick();
        end
        set_port(2, 1'b0, 32'h0, 1'b0);
        #1;
        total++; if (grant_busy !== 1'b0) begin bad++; $display("FAIL single_end_busy: got=%b exp=0", grant_busy); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL single_end_mvalid: got=%b exp=0", m_tvalid); end
    endtask

    task automatic test_round_robin();
        int prev;
        int g;
        pulse_reset();
        for (int p = 0; p < NS; p++) set_port(p, 1'b1, 32'(p * 16), 1'b0);
        prev = -1;
        for (int n = 0; n < 8; n++) begin
            g = n % NS;
            #1;
            total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rr_bubble n%0d: got=%b exp=0", n, m_tvalid); end
            tick();
            #1;
            total++; if (grant_idx !== 2'(g)) begin bad++; $display("FAIL rr_order n%0d: got=%0d exp=%0d", n, grant_idx, g); end
            total++; if (int'(grant_idx) == prev) begin bad++; $display("FAIL rr_repeat n%0d: got=%0d exp!=%0d", n, grant_idx, prev); end
            total++; if (m_tdata !== 32'(g * 16) || m_tlast !== 1'b0) begin bad++; $display("FAIL rr_beat0 n%0d: got=%h/%b exp=%h/0", n, m_tdata, m_tlast, 32'(g * 16)); end
            tick();
            set_port(g, 1'b1, 32'(g * 16 + 1), 1'b1);
            #1;
            total++; if (m_tdata !== 32'(g * 16 + 1) || m_tlast !== 1'b1) begin bad++; $display("FAIL rr_beat1 n%0d: got=%h/%b exp=%h/1", n, m_tdata, m_tlast, 32'(g * 16 + 1)); end
            tick();
            set_port(g, 1'b1, 32'(g * 16), 1'b0);
            prev = g;
        end
        clear_all();
        tick();
    endtask

    task automatic test_stall();
        logic [3:0] exp_rdy;
        pulse_reset();
        set_port(1, 1'b1, 32'hB0, 1'b0);
        #1;
        tick();
        set_port(0, 1'b1, 32'hC0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            m_tready = (RDY_T[c] == 1);
            set_port(1, 1'b1, 32'hB0 + 32'(IDX_T[c]), (IDX_T[c] == 2));
            exp_rdy = (RDY_T[c] == 1) ? 4'b0010 : 4'b0000;
            #1;
            total++; if (grant_idx !== 2'd1) begin bad++; $display("FAIL stall_grant c%0d: got=%0d exp=1", c, grant_idx); end
            total++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hB0 + 32'(IDX_T[c])) begin bad++; $display("FAIL stall_data c%0d: got=%b/%h exp=1/%h", c, m_tvalid, m_tdata, 32'hB0 + 32'(IDX_T[c])); end
            total++; if (s_tready !== exp_rdy) begin bad++; $display("FAIL stall_sready c%0d: got=%b exp=%b", c, s_tready, exp_rdy); end
            total++; if (m_tlast !== (IDX_T[c] == 2)) begin bad++; $display("FAIL stall_last c%0d: got=%b exp=%b", c, m_tlast, (IDX_T[c] == 2)); end
            tick();
        end
        set_port(1, 1'b0, 32'h0, 1'b0);
        m_tready = 1'b1;
        #1;
        total++; if (grant_busy !== 1'b0 || m_tvalid !== 1'b0) begin bad++; $display("FAIL stall_bubble: got=%b/%b exp=0/0", grant_busy, m_tvalid); end
        tick();
        #1;
        total++; if (grant_idx !== 2'd0 || m_tdata !== 32'hC0 || m_tlast !== 1'b1) begin bad++; $display("FAIL stall_port0: got=%0d/%h/%b exp=0/c0/1", grant_idx, m_tdata, m_tlast); end
        tick();
        set_port(0, 1'b0, 32'h0, 1'b0);
        #1;
        total++; if (grant_busy !== 1'b0) begin bad++; $display("FAIL stall_end: got=%b exp=0", grant_busy); end
    endtask

    task automatic test_overlen();
        set_port(3, 1'b1, 32'hD0, 1'b0);
        #1;
        tick();
        for (int b = 0; b < 4; b++) begin
            set_port(3, 1'b1, 32'hD0 + 32'(b), 1'b0);
            #1;
            total++; if (grant_idx !== 2'd3 || m_tdata !== 32'hD0 + 32'(b)) begin bad++; $display("FAIL ovl_data b%0d: got=%0d/%h exp=3/%h", b, grant_idx, m_tdata, 32'hD0 + 32'(b)); end
            total++; if (m_tlast !== (b == 3)) begin bad++; $display("FAIL ovl_forced_last b%0d: got=%b exp=%b", b, m_tlast, (b == 3)); end
            total++; if (err_overlen !== 1'b0) begin bad++; $display("FAIL ovl_err_early b%0d: got=%b exp=0", b, err_overlen); end
            tick();
        end
        set_port(3, 1'b1, 32'hD4, 1'b0);
        #1;
        total++; if (err_overlen !== 1'b1) begin bad++; $display("FAIL ovl_err_set: got=%b exp=1", err_overlen); end
        total++; if (grant_busy !== 1'b0) begin bad++; $display("FAIL ovl_exit: got=%b exp=0", grant_busy); end
        tick();
        for (int b = 4; b < 6; b++) begin
            set_port(3, 1'b1, 32'hD0 + 32'(b), (b == 5));
            #1;
            total++; if (grant_busy !== 1'b1 || m_tdata !== 32'hD0 + 32'(b)) begin bad++; $display("FAIL ovl_tail b%0d: got=%b/%h exp=1/%h", b, grant_busy, m_tdata, 32'hD0 + 32'(b)); end
            total++; if (m_tlast !== (b == 5)) begin bad++; $display("FAIL ovl_tail_last b%0d: got=%b exp=%b", b, m_tlast, (b == 5)); end
            tick();
        end
        set_port(3, 1'b0, 32'h0, 1'b0);
        #1;
        total++; if (err_overlen !== 1'b1) begin bad++; $display("FAIL ovl_sticky: got=%b exp=1", err_overlen); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        total++; if (err_overlen !== 1'b0) begin bad++; $display("FAIL ovl_clr: got=%b exp=0", err_overlen); end
    endtask

    task automatic test_reset_mid_packet();
        set_port(2, 1'b1, 32'hE0, 1'b0);
        #1;
        tick();
        #1;
        total++; if (grant_idx !== 2'd2 || m_tdata !== 32'hE0) begin bad++; $display("FAIL rstmid_beat1: got=%0d/%h exp=2/e0", grant_idx, m_tdata); end
        tick();
        set_port(2, 1'b1, 32'hE1, 1'b0);
        #1;
        total++; if (m_tdata !== 32'hE1) begin bad++; $display("FAIL rstmid_beat2: got=%h exp=e1", m_tdata); end
        areset = 1'b1;
        tick();
        areset = 1'b0;
        set_port(1, 1'b1, 32'hF0, 1'b1);
        set_port(3, 1'b1, 32'h30, 1'b1);
        #1;
        total++; if (s_tready !== 4'b0000) begin bad++; $display("FAIL rstmid_sready: got=%b exp=0000", s_tready); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_mvalid: got=%b exp=0", m_tvalid); end
        total++; if (grant_busy !== 1'b0 || grant_idx !== 2'd0) begin bad++; $display("FAIL rstmid_grant: got=%b/%0d exp=0/0", grant_busy, grant_idx); end
        tick();
        #1;
        total++; if (grant_idx !== 2'd1 || m_tdata !== 32'hF0) begin bad++; $display("FAIL rstmid_first_grant: got=%0d/%h exp=1/f0", grant_idx, m_tdata); end
        tick();
        clear_all();
        tick();
    endtask

    task automatic test_clr_collision();
        set_port(0, 1'b1, 32'h50, 1'b0);
        #1;
        tick();
        for (int b = 0; b < 4; b++) begin
            set_port(0, 1'b1, 32'h50 + 32'(b), 1'b0);
            err_clr = (b == 3);
            #1;
            total++; if (grant_idx !== 2'd0 || m_tlast !== (b == 3)) begin bad++; $display("FAIL coll_beat b%0d: got=%0d/%b exp=0/%b", b, grant_idx, m_tlast, (b == 3)); end
            tick();
        end
        err_clr = 1'b0;
        clear_all();
        #1;
        total++; if (err_overlen !== 1'b1) begin bad++; $display("FAIL coll_set_wins: got=%b exp=1", err_overlen); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_stall();
        test_overlen();
        test_reset_mid_packet();
        test_clr_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_pkt_rr_arbiter.md
# axis_pkt_rr_arbiter

Packet-locked round-robin arbiter that merges `NUM_S` AXI4-Stream slave ports onto one AXI4-Stream master port. A grant is held for a full packet (until the TLAST handshake), then released. The arbiter also enforces a maximum packet length. It sits between multiple stream producers and a single shared stream consumer, such as a DMA or VIP slave, using the same TDATA/TID/TDEST/TUSER widths as the stream VIP configuration.

## Interface
Parameters:
- `NUM_S`, 4: number of slave ports (2..16).
- `DATA_WIDTH`, 32: TDATA width; TKEEP/TSTRB width is `DATA_WIDTH/8`.
- `ID_WIDTH`, 4: TID width.
- `DEST_WIDTH`, 4: TDEST width.
- `USER_WIDTH`, 32: TUSER width.
- `MAX_BEATS`, 256: maximum beats per granted packet (≥2).

Ports (slave buses are flattened, with port i at slice `[i*W +: W]`):
- `aclk` in 1: clock; all logic on rising edge.
- `areset` in 1: synchronous, active-high reset.
- `s_tvalid` in `NUM_S`: per-port valid.
- `s_tready` out `NUM_S`: per-port ready.
- `s_tdata` in `NUM_S*DATA_WIDTH`.
- `s_tkeep`, `s_tstrb` in `NUM_S*DATA_WIDTH/8`.
- `s_tlast` in `NUM_S`.
- `s_tid` in `NUM_S*ID_WIDTH`.
- `s_tdest` in `NUM_S*DEST_WIDTH`.
- `s_tuser` in `NUM_S*USER_WIDTH`.
- `m_tvalid` out 1; `m_tready` in 1.
- `m_tdata`, `m_tkeep`, `m_tstrb`, `m_tlast`, `m_tid`, `m_tdest`, `m_tuser` out: the selected port's fields.
- `grant_idx` out `$clog2(NUM_S)`: currently granted port; valid while `grant_busy`=1.
- `grant_busy` out 1: a packet is in progress.
- `err_overlen` out 1: sticky; set when a packet is truncated at `MAX_BEATS`.
- `err_clr` in 1: clears `err_overlen`.

## Operation
FSM has two states, IDLE and BUSY.
- **IDLE:**
  - All `s_tready`=0 and `m_tvalid`=0.
  - If any `s_tvalid` bit is set, select the first requesting index searching upward from `last_grant+1` (mod `NUM_S`).
  - Register that index as `grant_idx` and `last_grant`, clear `beat_cnt`, and go to BUSY.
- **BUSY:** combinational pass-through of port g = `grant_idx`.
  - `m_tvalid` = `s_tvalid[g]`; `s_tready[g]` = `m_tready`; all other `s_tready` bits = 0.
  - `m_tdata`/`tkeep`/`tstrb`/`tid`/`tdest`/`tuser` = port g's fields.
  - `m_tlast` = `s_tlast[g]` OR (`beat_cnt` == `MAX_BEATS-1`).
  - `beat_cnt` increments on each handshake (`m_tvalid` & `m_tready`).
  - On a handshake with `m_tlast`=1, go to IDLE.
  - If the forced-last term caused `m_tlast` while `s_tlast[g]`=0, set `err_overlen`. The remaining beats of that packet arbitrate later as a new packet.
- `beat_cnt` is `$clog2(MAX_BEATS)` bits wide and never wraps: the forced last always exits BUSY first.
- `err_overlen`: if a set event and `err_clr` occur in the same cycle, set wins.
- In BUSY, requests from other ports are ignored. Round-robin fairness is per packet, not per beat.
- While idle, outputs hold the last selected port's fields. The data is don't-care with `m_tvalid`=0, but the outputs must not be X.

## Timing
- Reset, applied in any state including mid-packet:
  - Next cycle: state=IDLE, `s_tready`=0, `m_tvalid`=0, `grant_busy`=0, `grant_idx`=0, `beat_cnt`=0, `err_overlen`=0.
  - `last_grant`=`NUM_S-1`, so port 0 has first priority.
  - A packet interrupted by reset is abandoned; no TLAST is emitted.
- Arbitration latency: a request seen in IDLE at cycle N gives `grant_busy`=1 and possible first beat at cycle N+1.
- There is exactly one idle bubble cycle between consecutive packets.
- Data path in BUSY has zero latency (combinational). `m_tready`→`s_tready` is a combinational path.
- `m_tvalid` follows `s_tvalid[g]`, so AXI valid-stability holds provided the sources comply. The arbiter never drops `m_tvalid` mid-beat on its own.
- A single-beat packet (TLAST on the first beat) occupies 1 BUSY cycle plus 1 IDLE cycle.

## Test plan
- Reset, then port 2 alone sends a 3-beat packet (TDATA 0xA0,0xA1,0xA2, TID=5, TDEST=3) → master sees those 3 beats in order with TLAST on 0xA2, `grant_idx`=2, then IDLE.
- All 4 ports hold continuous 2-beat packets → grant order 0,1,2,3,0,… and no port receives two consecutive grants.
- Port 1 mid-packet with `m_tready` toggling 1,0,0,1 while port 0 asserts valid → port 0 is never granted until port 1's TLAST; beats are neither duplicated nor lost.
- `MAX_BEATS`=4, port 3 sends 6 beats with no TLAST until beat 6 → master sees beat 4 with forced TLAST and `err_overlen`=1, then beats 5–6 as a separate packet. Pulsing `err_clr` then returns `err_overlen` to 0.
- Assert `areset` on beat 2 of a 5-beat packet → the next cycle shows all `s_tready`=0, `m_tvalid`=0, `grant_busy`=0; after release the first grant goes to the lowest requesting index.
- `err_clr` and a forced-TLAST handshake in the same cycle → `err_overlen`=1 afterwards.
